// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle RV32I control FSM and its datapath.
// Latency: none, this is wiring only.
// Backpressure: none, there are no handshakes on this bundle.
// Ports: instruction fields and the ALU eq flag go into the controller (master).
// All datapath write enables, mux selects, the ALU op, illegal and state come out of it.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       eq;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       illegal;
  logic [3:0] state;

  // Controller side
  modport master (
    input  opcode, funct3, funct7b5, eq,
    output pc_write, adr_src, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_src,
           illegal, state
  );

  // Datapath side
  modport slave (
    output opcode, funct3, funct7b5, eq,
    input  pc_write, adr_src, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_src,
           illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences shared ALU, unified memory, regfile.
// Latency: 3-5 cycles per instruction (beq/bne 3; sw, R, I, jal 4; lw 5; illegal 2).
// Backpressure: none; memory is assumed to finish every access in one cycle.
// Ports: clk, rst (async, active-high) and a multicycle_ctrl_if.master bundle carrying
// opcode/funct3/funct7b5/eq in and all datapath enables, selects, ALU op, illegal, state out.
module multicycle_ctrl (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master ctrl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t cur;

  // Instruction-class legality checks used only in DECODE.
  logic alu_f3_ok;
  logic br_f3_ok;
  assign alu_f3_ok = (ctrl.funct3 == 3'b000) || (ctrl.funct3 == 3'b010) ||
                     (ctrl.funct3 == 3'b110) || (ctrl.funct3 == 3'b111);
  assign br_f3_ok  = (ctrl.funct3 == 3'b000) || (ctrl.funct3 == 3'b001);

  // Where DECODE goes; FETCH doubles as the illegal-instruction target.
  state_t decode_next;
  logic   decode_illegal;

  always_comb begin
    decode_next    = S_FETCH;
    decode_illegal = 1'b0;
    case (ctrl.opcode)
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_R: begin
        if (alu_f3_ok) decode_next = S_EXECR;
        else           decode_illegal = 1'b1;
      end
      OP_I: begin
        if (alu_f3_ok) decode_next = S_EXECI;
        else           decode_illegal = 1'b1;
      end
      OP_BR: begin
        if (br_f3_ok) decode_next = S_BRANCH;
        else          decode_illegal = 1'b1;
      end
      OP_JAL:  decode_next = S_JAL;
      default: decode_illegal = 1'b1;
    endcase
  end

  // ALU op for EXECR/EXECI. funct7b5 selects sub only for R-type so that
  // an addi whose immediate has bit 10 set is not mistaken for a subtract.
  logic [2:0] exec_alu_op;
  always_comb begin
    exec_alu_op = ALU_ADD;
    case (ctrl.funct3)
      3'b000:  exec_alu_op = (cur == S_EXECR && ctrl.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  exec_alu_op = ALU_SLT;
      3'b110:  exec_alu_op = ALU_OR;
      3'b111:  exec_alu_op = ALU_AND;
      default: exec_alu_op = ALU_ADD;
    endcase
  end

  // State register. Unreachable encodings fall back to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:    cur <= S_DECODE;
        S_DECODE:   cur <= decode_next;
        // sw and lw differ only in opcode bit 5
        S_MEMADR:   cur <= ctrl.opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  cur <= S_MEMWB;
        S_MEMWB:    cur <= S_FETCH;
        S_MEMWRITE: cur <= S_FETCH;
        S_EXECR:    cur <= S_ALUWB;
        S_EXECI:    cur <= S_ALUWB;
        S_ALUWB:    cur <= S_FETCH;
        S_BRANCH:   cur <= S_FETCH;
        S_JAL:      cur <= S_ALUWB;
        default:    cur <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from the state register. They are not registered:
  // the branch decision needs eq from the current BRANCH cycle, and the
  // FETCH enables must be live in the very first cycle after reset.
  // rst gates everything to 0 so an interrupted write can never complete.
  always_comb begin
    ctrl.pc_write    = 1'b0;
    ctrl.adr_src     = 1'b0;
    ctrl.ir_write    = 1'b0;
    ctrl.mem_write   = 1'b0;
    ctrl.reg_write   = 1'b0;
    ctrl.result_src  = 2'b00;
    ctrl.alu_src_a   = 2'b00;
    ctrl.alu_src_b   = 2'b00;
    ctrl.alu_control = ALU_ADD;
    ctrl.imm_src     = 2'b00;
    ctrl.illegal     = 1'b0;
    ctrl.state       = cur;

    case (ctrl.opcode)
      OP_SW:   ctrl.imm_src = 2'b01;
      OP_BR:   ctrl.imm_src = 2'b10;
      OP_JAL:  ctrl.imm_src = 2'b11;
      default: ctrl.imm_src = 2'b00;
    endcase

    case (cur)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.pc_write   = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b01;
        ctrl.illegal   = decode_illegal;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_control = exec_alu_op;
      end
      S_EXECI: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_src_b   = 2'b01;
        ctrl.alu_control = exec_alu_op;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_control = ALU_SUB;
        ctrl.pc_write    = (ctrl.funct3 == 3'b000) ? ctrl.eq :
                           (ctrl.funct3 == 3'b001) ? ~ctrl.eq : 1'b0;
      end
      S_JAL: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b10;
        ctrl.pc_write  = 1'b1;
      end
      default: begin
      end
    endcase

    if (rst) begin
      ctrl.pc_write    = 1'b0;
      ctrl.adr_src     = 1'b0;
      ctrl.ir_write    = 1'b0;
      ctrl.mem_write   = 1'b0;
      ctrl.reg_write   = 1'b0;
      ctrl.result_src  = 2'b00;
      ctrl.alu_src_a   = 2'b00;
      ctrl.alu_src_b   = 2'b00;
      ctrl.alu_control = 3'b000;
      ctrl.imm_src     = 2'b00;
      ctrl.illegal     = 1'b0;
      ctrl.state       = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction vectors with hand-written
// per-cycle expected control vectors; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       illegal;
  } vec_t;

  typedef struct packed {
    vec_t       v;
    logic [7:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t dut_vec();
    vec_t a;
    a.state       = bus.state;
    a.pc_write    = bus.pc_write;
    a.adr_src     = bus.adr_src;
    a.ir_write    = bus.ir_write;
    a.mem_write   = bus.mem_write;
    a.reg_write   = bus.reg_write;
    a.result_src  = bus.result_src;
    a.alu_src_a   = bus.alu_src_a;
    a.alu_src_b   = bus.alu_src_b;
    a.alu_control = bus.alu_control;
    a.imm_src     = bus.imm_src;
    a.illegal     = bus.illegal;
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Hand-written Moore table: the state-only part of every control vector.
  function automatic vec_t state_row(input logic [3:0] st, input logic [1:0] imm);
    vec_t v = '0;
    v.state   = st;
    v.imm_src = imm;
    case (st)
      4'd0:  begin v.pc_write = 1; v.ir_write = 1; v.result_src = 2'b10; v.alu_src_b = 2'b10; end
      4'd1:  begin v.alu_src_a = 2'b01; v.alu_src_b = 2'b01; end
      4'd2:  begin v.alu_src_a = 2'b10; v.alu_src_b = 2'b01; end
      4'd3:  begin v.adr_src = 1; end
      4'd4:  begin v.result_src = 2'b01; v.reg_write = 1; end
      4'd5:  begin v.adr_src = 1; v.mem_write = 1; end
      4'd6:  begin v.alu_src_a = 2'b10; end
      4'd7:  begin v.alu_src_a = 2'b10; v.alu_src_b = 2'b01; end
      4'd8:  begin v.reg_write = 1; end
      4'd9:  begin v.alu_src_a = 2'b10; v.alu_control = 3'b001; end
      4'd10: begin v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; v.pc_write = 1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Drives one instruction starting in FETCH and queues its per-cycle
  // expectations. seq holds up to 5 state codes, first in the top nibble.
  task automatic run_instr(input logic [7:0] tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic e, input logic [1:0] imm,
                           input int n, input logic [19:0] seq, input logic [2:0] alu,
                           input logic br_pcw, input logic ill);
    logic [19:0] s;
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.eq       = e;
    s = seq;
    for (int i = 0; i < n; i++) begin
      exp_t x;
      x.tag = tag;
      x.v   = state_row(s[19:16], imm);
      if (s[19:16] == 4'd6 || s[19:16] == 4'd7) x.v.alu_control = alu;
      if (s[19:16] == 4'd9) x.v.pc_write = br_pcw;
      if (s[19:16] == 4'd1) x.v.illegal = ill;
      exp_q.push_back(x);
      s = s << 4;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares the DUT against the next queued expectation each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        check($sformatf("vec_tag%0d_st%0d", x.tag, x.v.state), 32'(dut_vec()), 32'(x.v));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bus.opcode   = 7'b0110011;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.eq       = 1'b0;
    rst          = 1'b1;

    // Three reset cycles: everything 0 (imm_src too, as reset forces it).
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) exp_q.push_back('{v: '0, tag: 8'd0});
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    //        tag   opcode       f3      f7 eq imm   n  states                 alu     bpw ill
    run_instr(8'd1,  7'b0000011, 3'b010, 0, 0, 2'b00, 5, 20'h01234, 3'b000, 0, 0); // lw
    run_instr(8'd2,  7'b0100011, 3'b010, 0, 0, 2'b01, 4, 20'h01250, 3'b000, 0, 0); // sw
    run_instr(8'd3,  7'b0110011, 3'b000, 0, 0, 2'b00, 4, 20'h01680, 3'b000, 0, 0); // add
    run_instr(8'd4,  7'b0110011, 3'b000, 1, 0, 2'b00, 4, 20'h01680, 3'b001, 0, 0); // sub
    run_instr(8'd5,  7'b0010011, 3'b000, 1, 0, 2'b00, 4, 20'h01780, 3'b000, 0, 0); // addi, IR[30]=1
    run_instr(8'd6,  7'b0110011, 3'b010, 0, 0, 2'b00, 4, 20'h01680, 3'b101, 0, 0); // slt
    run_instr(8'd7,  7'b0010011, 3'b110, 0, 0, 2'b00, 4, 20'h01780, 3'b011, 0, 0); // ori
    run_instr(8'd8,  7'b0110011, 3'b111, 1, 0, 2'b00, 4, 20'h01680, 3'b010, 0, 0); // and, f7b5 ignored
    run_instr(8'd9,  7'b1100011, 3'b000, 0, 1, 2'b10, 3, 20'h01900, 3'b000, 1, 0); // beq taken
    run_instr(8'd10, 7'b1100011, 3'b000, 0, 0, 2'b10, 3, 20'h01900, 3'b000, 0, 0); // beq not taken
    run_instr(8'd11, 7'b1100011, 3'b001, 0, 0, 2'b10, 3, 20'h01900, 3'b000, 1, 0); // bne taken
    run_instr(8'd12, 7'b1100011, 3'b001, 0, 1, 2'b10, 3, 20'h01900, 3'b000, 0, 0); // bne not taken
    run_instr(8'd13, 7'b1101111, 3'b000, 0, 0, 2'b11, 4, 20'h01A80, 3'b000, 0, 0); // jal
    run_instr(8'd14, 7'b0000000, 3'b000, 0, 0, 2'b00, 2, 20'h01000, 3'b000, 0, 1); // bad opcode
    run_instr(8'd15, 7'b0110011, 3'b001, 0, 0, 2'b00, 2, 20'h01000, 3'b000, 0, 1); // R funct3 001
    run_instr(8'd16, 7'b1100011, 3'b100, 0, 1, 2'b10, 2, 20'h01000, 3'b000, 0, 1); // blt unsupported

    // sw interrupted by reset in MEMWRITE: 3 cycles queued, then reset lands.
    run_instr(8'd17, 7'b0100011, 3'b010, 0, 0, 2'b01, 3, 20'h01200, 3'b000, 0, 0);
    check("pre_rst_state", 32'(bus.state), 32'd5);
    check("pre_rst_mem_write", 32'(bus.mem_write), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("async_rst_state", 32'(bus.state), 32'd0);
    check("async_rst_adr_src", 32'(bus.adr_src), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Recovery: a fresh add runs from FETCH.
    run_instr(8'd18, 7'b0110011, 3'b000, 0, 0, 2'b00, 4, 20'h01680, 3'b000, 0, 0);

    @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
